top_core: RTL and testbench

- Minimal SoC top with three parts:
  - an SPI slave that loads a 32-word instruction memory;
  - a tiny accumulator processor that executes from that memory when enabled;
  - a 32-bit GPIO output register written by the processor.
- Everything runs in the single clk_i domain. SPI pins are oversampled, not used as clocks.
- Intended for bring-up: host loads a program over SPI, pulses enable, then checks gpio_o.

---
 rtl/top_core_pkg.sv | 35 +++
 rtl/spi_mem_slave.sv | 122 ++++++++++++
 rtl/top_core.sv | 106 ++++++++++
 tb/tb_top_core.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_core_pkg.sv
// Shared constants and types for the top_core bring-up SoC (SPI loader, accumulator core, GPIO).
package top_core_pkg;

  localparam int          IDX_W            = 5;
  localparam logic [31:0] MEM_BASE_DEFAULT = 32'h0000_0080;

  localparam logic [3:0] OP_SYS  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_OUT  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_BNZ  = 4'h5;

  localparam logic [31:0] HALT_WORD = 32'h0000_0FFF;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    SPI_IDLE,
    SPI_HDR,
    SPI_WDATA,
    SPI_READ,
    SPI_DONE
  } spi_state_e;

  // True when a byte address falls inside the memory window [base, base + 4*words).
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input int unsigned words);
    logic [31:0] span;
    span = 32'(words) << 2;
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/spi_mem_slave.sv
// SPI mode-0 slave clocked by the system clock: oversamples the pins and turns
// 72-bit write frames and 40-bit-header read frames into memory accesses.
module spi_mem_slave
  import top_core_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned MEM_WORDS   = 32,
  parameter logic [31:0] MEM_BASE    = MEM_BASE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs,
  input  logic             sdi,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [31:0]      wr_data,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [31:0]      rd_data,
  output logic             sdo_bit,
  output spi_state_e       state
);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, sdi_s;
  logic                   sclk_rise, sclk_fall, cs_fall;
  logic [62:0]            shift_q;
  logic [63:0]            nxt;
  logic [6:0]             bit_cnt;
  logic [31:0]            rd_shift;
  logic [5:0]             rd_left;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  // Shift register including the bit arriving on this sclk rise; at bit 40 it
  // holds {cmd, addr}, at bit 72 it holds {addr, data} (cmd has shifted out).
  assign nxt     = {shift_q, sdi_s};
  assign rd_idx  = nxt[6:2];
  assign sdo_bit = rd_shift[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sdi_sync  <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  // wr_en is a single-cycle strobe with wr_idx/wr_data valid in the same cycle;
  // the memory always accepts, so there is no ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SPI_IDLE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      rd_shift <= '0;
      rd_left  <= '0;
      wr_en    <= 1'b0;
      wr_idx   <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (cs_fall) begin
        state   <= SPI_HDR;
        bit_cnt <= '0;
        shift_q <= '0;
      end else if (cs_s) begin
        state   <= SPI_IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          SPI_HDR: if (sclk_rise) begin
            shift_q <= nxt[62:0];
            bit_cnt <= bit_cnt + 7'd1;
            if (bit_cnt == 7'd39) begin
              if (nxt[39:32] == CMD_WRITE) begin
                state <= SPI_WDATA;
              end else if (nxt[39:32] == CMD_READ) begin
                state    <= SPI_READ;
                rd_shift <= in_window(nxt[31:0], MEM_BASE, MEM_WORDS) ? rd_data : '0;
                rd_left  <= 6'd32;
              end else begin
                state <= SPI_DONE;
              end
            end
          end
          SPI_WDATA: if (sclk_rise) begin
            shift_q <= nxt[62:0];
            bit_cnt <= bit_cnt + 7'd1;
            if (bit_cnt == 7'd71) begin
              wr_en   <= in_window(nxt[63:32], MEM_BASE, MEM_WORDS);
              wr_idx  <= nxt[38:34];
              wr_data <= nxt[31:0];
              state   <= SPI_DONE;
            end
          end
          SPI_READ: if (sclk_fall) begin
            rd_shift <= {rd_shift[30:0], 1'b0};
            rd_left  <= rd_left - 6'd1;
            if (rd_left == 6'd1) state <= SPI_DONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/top_core.sv
// Bring-up SoC top: SPI-loaded 32-word instruction memory, accumulator core and
// a GPIO output register written by the core's OUT instruction.
module top_core
  import top_core_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 32,
  parameter logic [31:0] MEM_BASE    = MEM_BASE_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic        en_ifetch_i,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  input  logic        spi_sdi0,
  input  logic        spi_sdi1,
  input  logic        spi_sdi2,
  input  logic        spi_sdi3,
  output logic [1:0]  spi_mode,
  output logic        spi_sdo0,
  output logic        spi_sdo1,
  output logic        spi_sdo2,
  output logic        spi_sdo3,
  output logic [31:0] gpio_o
);

  logic [31:0]      mem [MEM_WORDS];
  logic             spi_wr_en;
  logic [IDX_W-1:0] spi_wr_idx, spi_rd_idx;
  logic [31:0]      spi_wr_data, spi_rd_data;
  logic             spi_sdo_bit;
  spi_state_e       spi_state;
  logic             unused_quad_lanes;

  logic [IDX_W-1:0] pc;
  logic [31:0]      acc;
  logic             halted;
  logic [31:0]      instr;
  logic [3:0]       op;
  logic [27:0]      imm;
  logic             run;

  assign spi_mode          = 2'b00;
  assign spi_sdo1          = 1'b0;
  assign spi_sdo2          = 1'b0;
  assign spi_sdo3          = 1'b0;
  assign unused_quad_lanes = spi_sdi1 ^ spi_sdi2 ^ spi_sdi3;

  spi_mem_slave #(
    .SYNC_STAGES (SYNC_STAGES),
    .MEM_WORDS   (MEM_WORDS),
    .MEM_BASE    (MEM_BASE)
  ) u_spi (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .sclk    (spi_sclk),
    .cs      (spi_cs),
    .sdi     (spi_sdi0),
    .wr_en   (spi_wr_en),
    .wr_idx  (spi_wr_idx),
    .wr_data (spi_wr_data),
    .rd_idx  (spi_rd_idx),
    .rd_data (spi_rd_data),
    .sdo_bit (spi_sdo_bit),
    .state   (spi_state)
  );

  assign spi_rd_data = mem[spi_rd_idx];
  // Read data only drives the pin while a read response is being shifted out.
  assign spi_sdo0    = (spi_state == SPI_READ) & spi_sdo_bit;

  // Contents are not reset; a same-cycle write is seen by the fetch one cycle later.
  always_ff @(posedge clk_i) begin
    if (spi_wr_en) mem[spi_wr_idx] <= spi_wr_data;
  end

  assign instr = mem[pc];
  assign op    = instr[31:28];
  assign imm   = instr[27:0];
  assign run   = fetch_enable_i & en_ifetch_i & ~halted;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc     <= '0;
      acc    <= '0;
      halted <= 1'b0;
      gpio_o <= '0;
    end else if (run) begin
      pc <= pc + 1'b1;
      case (op)
        OP_SYS: if (instr == HALT_WORD) begin
          halted <= 1'b1;
          pc     <= pc;
        end
        OP_LDI:  acc    <= {4'b0, imm};
        OP_ADDI: acc    <= acc + {{4{imm[27]}}, imm};
        OP_OUT:  gpio_o <= acc;
        OP_JMP:  pc     <= imm[6:2];
        OP_BNZ:  if (acc != '0) pc <= imm[6:2];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_top_core.sv
// Bench for top_core: loads programs over oversampled SPI and checks memory
// reads, GPIO results and core state against an ISA-level reference model.
module tb_top_core;
  import top_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, en_ifetch;
  logic        spi_sclk, spi_cs, spi_sdi0, spi_sdi1, spi_sdi2, spi_sdi3;
  logic [1:0]  spi_mode;
  logic        spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3;
  logic [31:0] gpio;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_model [32];
  logic [31:0] m_acc, m_gpio;
  int          m_pc;
  bit          m_halted;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } spi_vec_t;

  spi_vec_t vecs[7];

  always #5 clk = ~clk;

  top_core dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .fetch_enable_i (fetch_en),
    .en_ifetch_i    (en_ifetch),
    .spi_sclk       (spi_sclk),
    .spi_cs         (spi_cs),
    .spi_sdi0       (spi_sdi0),
    .spi_sdi1       (spi_sdi1),
    .spi_sdi2       (spi_sdi2),
    .spi_sdi3       (spi_sdi3),
    .spi_mode       (spi_mode),
    .spi_sdo0       (spi_sdo0),
    .spi_sdo1       (spi_sdo1),
    .spi_sdo2       (spi_sdo2),
    .spi_sdo3       (spi_sdo3),
    .gpio_o         (gpio)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit in_range(input logic [31:0] addr);
    return (addr >= 32'h80) && (addr < 32'h100);
  endfunction

  task automatic model_reset();
    m_pc = 0; m_acc = '0; m_gpio = '0; m_halted = 1'b0;
  endtask

  task automatic model_step(output bit did_out);
    logic [31:0] w;
    logic [27:0] imm;
    int          nxt;
    did_out = 1'b0;
    if (m_halted) return;
    w   = mem_model[m_pc];
    imm = w[27:0];
    nxt = (m_pc + 1) % 32;
    case (w >> 28)
      0: if (w == 32'h0000_0FFF) begin m_halted = 1'b1; nxt = m_pc; end
      1: m_acc = imm;
      2: m_acc = m_acc + imm - (imm >= 28'h800_0000 ? 32'h1000_0000 : 32'h0);
      3: begin m_gpio = m_acc; did_out = 1'b1; end
      4: nxt = int'((imm / 4) % 32);
      5: if (m_acc != 0) nxt = int'((imm / 4) % 32);
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // ---------------- drivers (all start and end on a falling clk edge) ----------------
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, " rst gpio"}, gpio, 32'h0);
    check({tag, " rst pc"}, 32'(dut.pc), 32'h0);
    check({tag, " rst acc"}, dut.acc, 32'h0);
    check({tag, " rst halted"}, 32'(dut.halted), 32'h0);
    check({tag, " rst sdo0"}, 32'(spi_sdo0), 32'h0);
    fetch_en = 1'b0; en_ifetch = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic spi_frame(input logic [71:0] bits, input int nbits, output logic [31:0] rdata);
    rdata = '0;
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_sdi0 = bits[71-i];
      spi_sclk = 1'b0;
      repeat (5) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (5) @(negedge clk);
      if (i >= 39 && i <= 70) rdata[70-i] = spi_sdo0;
    end
    spi_sclk = 1'b0;
    repeat (5) @(negedge clk);
    spi_cs = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic spi_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    spi_frame({CMD_WRITE, addr, data}, 72, dummy);
    if (in_range(addr)) mem_model[(addr - 32'h80) / 4] = data;
  endtask

  task automatic spi_read(input logic [31:0] addr, output logic [31:0] data);
    spi_frame({CMD_READ, addr, 32'h0}, 72, data);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    return in_range(addr) ? mem_model[(addr - 32'h80) / 4] : 32'h0;
  endfunction

  task automatic run_checked(input int n, input bit use_q, input string tag);
    bit did;
    fetch_en = 1'b1; en_ifetch = 1'b1;
    for (int k = 0; k < n; k++) begin
      model_step(did);
      @(negedge clk);
      check({tag, " gpio"}, gpio, m_gpio);
      check({tag, " pc"}, 32'(dut.pc), 32'(m_pc));
      check({tag, " acc"}, dut.acc, m_acc);
      if (did && use_q) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL %s out: unexpected OUT of %h, none required", tag, gpio);
        end else begin
          check({tag, " out"}, gpio, exp_q.pop_front());
        end
      end
    end
    fetch_en = 1'b0; en_ifetch = 1'b0;
  endtask

  task automatic load_prog(input logic [31:0] words[$]);
    foreach (words[i]) spi_write(32'h80 + 32'(4 * i), words[i]);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] r;
    logic [31:0] prog[$];
    fetch_en = 1'b0; en_ifetch = 1'b0;
    spi_sclk = 1'b0; spi_cs = 1'b1; spi_sdi0 = 1'b0;
    spi_sdi1 = 1'b1; spi_sdi2 = 1'b0; spi_sdi3 = 1'b1;
    model_reset();

    do_reset("init");
    check("spi_mode", 32'(spi_mode), 32'h0);
    check("sdo1..3", 32'({spi_sdo1, spi_sdo2, spi_sdo3}), 32'h0);

    // SPI write/read vectors, including window edges and rejected addresses.
    vecs[0] = '{32'h0000_0080, 32'hA5A5_0001, 32'h0000_0080, 32'hA5A5_0001};
    vecs[1] = '{32'h0000_0084, 32'hDEAD_BEEF, 32'h0000_0084, 32'hDEAD_BEEF};
    vecs[2] = '{32'h0000_0100, 32'h1234_5678, 32'h0000_0080, 32'hA5A5_0001};
    vecs[3] = '{32'h0000_007C, 32'h1111_1111, 32'h0000_007C, 32'h0000_0000};
    vecs[4] = '{32'h0000_00FC, 32'hCAFE_F00D, 32'h0000_00FC, 32'hCAFE_F00D};
    vecs[5] = '{32'h0000_0180, 32'h5555_AAAA, 32'h0000_0080, 32'hA5A5_0001};
    vecs[6] = '{32'h0000_0088, 32'h0000_0042, 32'h0000_0100, 32'h0000_0000};
    foreach (vecs[i]) begin
      spi_write(vecs[i].waddr, vecs[i].wdata);
      spi_read(vecs[i].raddr, r);
      check($sformatf("vec%0d read", i), r, vecs[i].exp);
    end

    // Basic program: LDI 10; ADDI 20; OUT; HALT.
    prog = '{32'h1000_000A, 32'h2000_0014, 32'h3000_0000, 32'h0000_0FFF};
    load_prog(prog);
    run_checked(10, 1'b0, "p1");
    check("p1 final gpio", gpio, 32'd30);
    check("p1 halted", 32'(dut.halted), 32'h1);
    repeat (10) @(negedge clk);
    check("p1 gpio held", gpio, 32'd30);

    do_reset("p1 reset");
    fetch_en = 1'b1; en_ifetch = 1'b0;
    repeat (10) @(negedge clk);
    check("ifetch off gpio", gpio, 32'h0);
    check("ifetch off pc", 32'(dut.pc), 32'h0);
    check("ifetch off acc", dut.acc, 32'h0);
    fetch_en = 1'b0;

    run_checked(2, 1'b0, "partial");
    fetch_en = 1'b1; en_ifetch = 1'b1;
    do_reset("midrun");
    run_checked(10, 1'b0, "rerun");
    check("rerun final gpio", gpio, 32'd30);

    // Countdown loop, OUT after the loop.
    prog = '{32'h1000_0003, 32'h2FFF_FFFF, 32'h5000_0084, 32'h3000_0000, 32'h0000_0FFF};
    load_prog(prog);
    do_reset("loopA");
    exp_q = '{32'd0};
    run_checked(12, 1'b1, "loopA");
    check("loopA halted", 32'(dut.halted), 32'h1);
    check("loopA outs left", 32'(exp_q.size()), 32'h0);

    // Countdown loop, OUT inside the loop.
    prog = '{32'h1000_0005, 32'h2FFF_FFFF, 32'h3000_0000, 32'h5000_0084, 32'h0000_0FFF};
    load_prog(prog);
    do_reset("loopB");
    exp_q = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    run_checked(20, 1'b1, "loopB");
    check("loopB final gpio", gpio, 32'h0);
    check("loopB outs left", 32'(exp_q.size()), 32'h0);

    // Aborted write frame, then a complete one to the same word.
    spi_frame({CMD_WRITE, 32'h0000_0088, 32'h1234_5678}, 50, r);
    spi_read(32'h88, r);
    check("abort no write", r, model_read(32'h88));
    spi_write(32'h88, 32'h0BAD_F00D);
    spi_read(32'h88, r);
    check("after abort write", r, 32'h0BAD_F00D);

    // Random straight-line programs with forward branches, plus a random-address write.
    for (int t = 0; t < 3; t++) begin
      logic [31:0] waddr, raddr;
      prog = {};
      for (int i = 0; i < 6; i++) begin
        logic [31:0] w;
        if (i == 5) w = 32'h0000_0FFF;
        else begin
          case ($urandom_range(0, 5))
            0: w = {4'h1, 28'($urandom)};
            1: w = {4'h2, 28'($urandom)};
            2: w = {4'h3, 28'($urandom)};
            3: w = {4'($urandom_range(6, 15)), 28'($urandom)};
            4: w = {4'h5, 21'($urandom), 5'($urandom_range(i + 1, 5)), 2'($urandom)};
            default: w = {4'h4, 21'($urandom), 5'($urandom_range(i + 1, 5)), 2'($urandom)};
          endcase
        end
        prog.push_back(w);
      end
      load_prog(prog);
      do_reset($sformatf("rnd%0d", t));
      run_checked(10, 1'b0, $sformatf("rnd%0d", t));
      waddr = $urandom();
      spi_write(waddr, $urandom());
      raddr = 32'h80 + 32'(4 * $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) raddr = waddr;
      spi_read(raddr, r);
      check($sformatf("rnd%0d read %h", t, raddr), r, model_read(raddr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
